// File: rtl/lsu_m.sv
// lsu_m: RV32I load/store unit with request/grant/response data-memory handshake
module lsu_m (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [31:0] w_ea;
  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  assign w_ea       = rs1 + offset;
  assign w_illegal  = is_store ? (funct3 >= 3'b011) : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
  assign w_misalign = (funct3[1:0] == 2'b01 && w_ea[0]) || (funct3[1:0] == 2'b10 && w_ea[1:0] != 2'b00);
  assign w_be       = funct3[1:0] == 2'b00 ? 4'b0001 << w_ea[1:0] :
                      funct3[1:0] == 2'b01 ? (w_ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata    = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                      funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  // lane selection uses the offset latched at start, not the live inputs
  assign w_byte     = mem_rdata[{r_lo, 3'b000} +: 8];
  assign w_half     = mem_rdata[{r_lo[1], 4'b0000} +: 16];
  assign w_ld       = r_f3[1:0] == 2'b00 ? {{24{w_byte[7] & ~r_f3[2]}}, w_byte} :
                      r_f3[1:0] == 2'b01 ? {{16{w_half[15] & ~r_f3[2]}}, w_half} : mem_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_store     <= 1'b0;
      r_f3        <= 3'b000;
      r_lo        <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      load_result <= 32'h0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_be      <= 4'h0;
      mem_wdata   <= 32'h0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_store <= is_store;
          r_f3    <= funct3;
          r_lo    <= w_ea[1:0];
          busy    <= 1'b1;
          if (w_illegal || w_misalign) begin
            r_state <= DONE;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            r_state   <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {w_ea[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
          end
        end
        REQ: if (mem_gnt) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          r_state <= r_store ? DONE : WAIT;
          done    <= r_store;
        end
        WAIT: if (mem_rvalid) begin
          load_result <= w_ld;
          r_state     <= DONE;
          done        <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_m.sv
// tb_lsu_m: scoreboard bench for lsu_m with a behavioural address/lane model
module tb_lsu_m;
  logic        clk = 0, reset = 0, start = 0, is_store = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1 = 0, offset = 0, store_data = 0;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] load_result, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  int n_chk = 0, n_err = 0;
  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} req_t;
  typedef struct {logic flt; logic [31:0] lr;} cmp_t;
  req_t rq[$];
  cmp_t cq[$];
  logic [31:0] exp_lr = 0;

  lsu_m dut (.clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .rs1(rs1), .offset(offset), .store_data(store_data), .busy(busy), .done(done), .fault(fault),
    .load_result(load_result), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares every presented request and completion against the queues
  always @(negedge clk) if (!reset) begin
    if (mem_req) begin
      chk("req_expected", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) begin
        chk("mem_addr", mem_addr, rq[0].addr);
        chk("mem_be", {28'h0, mem_be}, {28'h0, rq[0].be});
        chk("mem_wdata", mem_wdata, rq[0].wdata);
        chk("mem_we", {31'h0, mem_we}, {31'h0, rq[0].we});
        if (mem_gnt) void'(rq.pop_front());
      end
    end
    if (done) begin
      chk("done_expected", 32'(cq.size() > 0), 1);
      if (cq.size() > 0) begin
        chk("fault", {31'h0, fault}, {31'h0, cq[0].flt});
        chk("load_result", load_result, cq[0].lr);
        chk("busy_in_done", {31'h0, busy}, 1);
        void'(cq.pop_front());
      end
    end else if (fault) chk("fault_without_done", {31'h0, fault}, 0);
  end

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] o,
                       input logic [31:0] sd, input logic [31:0] rd, input int gw, input int rw);
    logic [31:0] ea, v, sz;
    logic flt;
    req_t r;
    cmp_t c;
    ea  = a + o;
    sz  = 32'd1 << (f3 % 4);
    flt = st ? (f3 > 2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!flt && (ea % sz) != 0) flt = 1;
    if (!flt) begin
      r.addr  = ea - ea % 4;
      r.be    = sz == 1 ? 4'(1 << (ea % 4)) : sz == 2 ? (ea % 4 >= 2 ? 4'hC : 4'h3) : 4'hF;
      r.wdata = sz == 1 ? sd[7:0] * 32'h01010101 : sz == 2 ? sd[15:0] * 32'h00010001 : sd;
      r.we    = st;
      rq.push_back(r);
      if (!st) begin
        if (sz == 1) begin
          v = (rd >> (8 * (ea % 4))) & 32'hFF;
          if (f3 == 0 && v >= 128) v = v - 256;
        end else if (sz == 2) begin
          v = (rd >> (16 * ((ea % 4) / 2))) & 32'hFFFF;
          if (f3 == 1 && v >= 32768) v = v - 65536;
        end else v = rd;
        exp_lr = v;
      end
    end
    c.flt = flt;
    c.lr  = exp_lr;
    cq.push_back(c);
    start = 1; is_store = st; funct3 = f3; rs1 = a; offset = o; store_data = sd;
    tick();
    start = 0; rs1 = $urandom; offset = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (flt) chk("fault_latency", {31'h0, done}, 1);
    else begin
      chk("req_latency", {31'h0, mem_req}, 1);
      repeat (gw) begin
        start = 1'($urandom); is_store = 1'($urandom);
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        tick();
      end
      start = 0; mem_rvalid = 0; mem_gnt = 1;
      tick();
      mem_gnt = 0;
      if (st) chk("store_done_latency", {31'h0, done}, 1);
      else begin
        chk("wait_no_done", {31'h0, done}, 0);
        repeat (rw) begin
          start = 1'($urandom);
          tick();
        end
        start = 0; mem_rvalid = 1; mem_rdata = rd;
        tick();
        mem_rvalid = 0; mem_rdata = $urandom;
        chk("load_done_latency", {31'h0, done}, 1);
      end
    end
    tick();
    chk("idle_after_done", {30'h0, done, busy}, 0);
  endtask

  task automatic rst_test(input bit in_wait);
    req_t r;
    r.addr = 32'h3000; r.be = 4'hF; r.wdata = 32'h0; r.we = 0;
    rq.push_back(r);
    start = 1; is_store = 0; funct3 = 3'b010; rs1 = 32'h3000; offset = 0; store_data = 0;
    tick();
    start = 0;
    if (in_wait) begin
      mem_gnt = 1;
      tick();
      mem_gnt = 0;
    end
    #2 reset = 1;
    #1;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    rq.delete(); cq.delete(); exp_lr = 0;
    tick();
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 0;
    tick();
    chk("rst_late_rvalid_lr", load_result, 0);
    chk("rst_busy_after", {31'h0, busy}, 0);
  endtask

  initial begin
    #1 reset = 1;
    repeat (2) tick();
    reset = 0;
    tick();
    chk("reset_busy", {31'h0, busy}, 0);
    chk("reset_done_fault", {30'h0, done, fault}, 0);
    chk("reset_req_we", {30'h0, mem_req, mem_we}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_be", {28'h0, mem_be}, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_lr", load_result, 0);
    do_op(1, 3'b000, 32'h1000, 32'hFFFFFFFF, 32'hA5, 0, 3, 0);
    do_op(0, 3'b000, 32'h2000, 32'h2, 0, 32'h80FF7F00, 0, 0);
    do_op(0, 3'b100, 32'h2000, 32'h2, 0, 32'h80FF7F00, 1, 1);
    do_op(0, 3'b001, 32'h2000, 32'h2, 0, 32'h80011234, 0, 2);
    do_op(0, 3'b010, 32'h2000, 32'h0, 0, 32'h12345678, 2, 0);
    do_op(0, 3'b010, 32'h2000, 32'h1, 0, 32'hFFFFFFFF, 0, 0);
    do_op(0, 3'b011, 32'h2000, 32'h0, 0, 32'hFFFFFFFF, 0, 0);
    do_op(1, 3'b011, 32'h2000, 32'h0, 32'h55, 0, 0, 0);
    do_op(1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 0, 1, 0);
    do_op(1, 3'b001, 32'h2000, 32'h3, 32'h1234, 0, 0, 0);
    for (int i = 0; i < 150; i++)
      do_op(1'($urandom), 3'($urandom), $urandom,
            ($urandom % 4 != 0) ? $urandom_range(0, 64) - 32 : $urandom,
            $urandom, $urandom, $urandom % 4, $urandom % 3);
    rst_test(1);
    rst_test(0);
    do_op(0, 3'b101, 32'h4000, 32'h2, 0, 32'h9876ABCD, 1, 1);
    chk("queues_drained", 32'(rq.size() + cq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
